// File: rtl/devbus_arbiter.sv
// devbus_arbiter: round-robin arbiter and single-cycle transaction sequencer for the
// shared memory-mapped device bus (address, wrtEn, bidirectional dbus).
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   req[NREQ]         per-requester request level, held until the matching done
//   we[NREQ]          per-requester write (1) / read (0), held with req
//   addr, wdata       packed NREQ*DBITS; requester i uses [i*DBITS +: DBITS]
//   gnt[NREQ]         one-hot registered grant, high from XFER through DONE
//   done[NREQ]        one-hot single-cycle completion pulse
//   rdata             read data, valid in the done cycle, held until the next read
//   bus_addr          device bus address (IDLE_ADDR when idle)
//   bus_wrtEn         device bus write enable
//   dbus              device bus data, driven only during XFER of a write
//
// Optional feature: define DEVBUS_TURNAROUND_EN to insert a one-cycle TURN state
// after every read so devices get a dead cycle to release dbus.

module devbus_arbiter #(
    parameter int              DBITS     = 32,
    parameter int              NREQ      = 2,
    parameter logic [DBITS-1:0] IDLE_ADDR = {DBITS{1'b1}}
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       we,
    input  logic [NREQ*DBITS-1:0] addr,
    input  logic [NREQ*DBITS-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic [DBITS-1:0]      rdata,
    output logic [DBITS-1:0]      bus_addr,
    output logic                  bus_wrtEn,
    inout  wire  [DBITS-1:0]      dbus
);

    localparam int PW = $clog2(NREQ);

`ifdef DEVBUS_TURNAROUND_EN
    typedef enum logic [1:0] {StIdle, StXfer, StDone, StTurn} state_t;
`else
    typedef enum logic [1:0] {StIdle, StXfer, StDone} state_t;
`endif

    state_t           state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    win_q;
    logic             lat_we;
    logic [DBITS-1:0] lat_wdata;
    logic             dbus_oe;

    logic             win_found;
    logic [PW-1:0]    win_idx;
    int               cand;

    // Search starts at the pointer; the first set request wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr;
        cand      = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = PW'(cand);
            end
        end
    end

    // The output enable is registered alongside bus_wrtEn, so dbus is only ever
    // driven while bus_wrtEn is high.
    assign dbus = dbus_oe ? lat_wdata : {DBITS{1'bz}};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            gnt       <= '0;
            done      <= '0;
            rdata     <= '0;
            bus_addr  <= IDLE_ADDR;
            bus_wrtEn <= 1'b0;
            dbus_oe   <= 1'b0;
            ptr       <= '0;
            win_q     <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    done <= '0;
                    if (win_found) begin
                        gnt       <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
                        win_q     <= win_idx;
                        lat_we    <= we[win_idx];
                        lat_wdata <= wdata[win_idx*DBITS +: DBITS];
                        bus_addr  <= addr[win_idx*DBITS +: DBITS];
                        bus_wrtEn <= we[win_idx];
                        dbus_oe   <= we[win_idx];
                        state     <= StXfer;
                    end
                end
                StXfer: begin
                    if (!lat_we) rdata <= dbus;
                    done      <= {{(NREQ-1){1'b0}}, 1'b1} << win_q;
                    bus_addr  <= IDLE_ADDR;
                    bus_wrtEn <= 1'b0;
                    dbus_oe   <= 1'b0;
                    ptr       <= (int'(win_q) == NREQ - 1) ? '0 : win_q + 1'b1;
                    state     <= StDone;
                end
                StDone: begin
                    done <= '0;
                    gnt  <= '0;
`ifdef DEVBUS_TURNAROUND_EN
                    state <= lat_we ? StIdle : StTurn;
`else
                    state <= StIdle;
`endif
                end
`ifdef DEVBUS_TURNAROUND_EN
                StTurn: begin
                    state <= StIdle;
                end
`endif
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_devbus_arbiter.sv
// Scoreboard bench for devbus_arbiter with a 10-bit LED register device model at
// IDLE_ADDR-1. Stimulus pushes expected XFER and done events; a negedge monitor
// pops and compares whenever the bus is active or a done pulse appears.

module tb_devbus_arbiter;

    localparam int          DBITS     = 32;
    localparam int          NREQ      = 2;
    localparam logic [31:0] IDLE_ADDR = 32'hFFFF_FFFF;
    localparam logic [31:0] LED_ADDR  = IDLE_ADDR - 32'd1;
`ifdef DEVBUS_TURNAROUND_EN
    localparam int          RD_GAP    = 4;
`else
    localparam int          RD_GAP    = 3;
`endif

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ-1:0]       we = '0;
    logic [NREQ*DBITS-1:0] addr = '0;
    logic [NREQ*DBITS-1:0] wdata = '0;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic [DBITS-1:0]      rdata;
    logic [DBITS-1:0]      bus_addr;
    logic                  bus_wrtEn;
    wire  [DBITS-1:0]      dbus;

    devbus_arbiter #(.DBITS(DBITS), .NREQ(NREQ), .IDLE_ADDR(IDLE_ADDR)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .bus_addr  (bus_addr),
        .bus_wrtEn (bus_wrtEn),
        .dbus      (dbus)
    );

    always #5 clk = ~clk;

    // LED device: captures on write, drives dbus on read of its address.
    logic [9:0] led = '0;
    assign dbus = (bus_addr == LED_ADDR && !bus_wrtEn) ? {22'b0, led} : {DBITS{1'bz}};
    always @(posedge clk) if (bus_wrtEn && bus_addr == LED_ADDR) led <= dbus[9:0];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
        logic [1:0]  gnt;
    } xfer_t;

    typedef struct {
        logic [1:0]  done;
        logic        rd;
        logic [31:0] rdata;
        int          gap;
    } done_t;

    xfer_t xfer_q[$];
    done_t done_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;
    int last_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus_addr != IDLE_ADDR) begin
                if (xfer_q.size() == 0) begin
                    check("unexpected_xfer", 64'(bus_addr), 64'(IDLE_ADDR));
                end else begin
                    xfer_t e;
                    e = xfer_q.pop_front();
                    check("xfer_addr", 64'(bus_addr), 64'(e.addr));
                    check("xfer_wrtEn", 64'(bus_wrtEn), 64'(e.wr));
                    check("xfer_dbus", 64'(dbus), 64'(e.data));
                    check("xfer_gnt", 64'(gnt), 64'(e.gnt));
                end
            end
            if (done != '0) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'd0);
                end else begin
                    done_t d;
                    d = done_q.pop_front();
                    check("done_onehot", 64'(done), 64'(d.done));
                    check("gnt_in_done", 64'(gnt), 64'(d.done));
                    check("bus_idle_in_done", {31'b0, bus_wrtEn, bus_addr},
                          {31'b0, 1'b0, IDLE_ADDR});
                    if (d.rd) check("rdata", 64'(rdata), 64'(d.rdata));
                    if (d.gap != 0) check("done_gap", 64'(cyc - last_done), 64'(d.gap));
                end
                last_done = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic wr, input logic [31:0] data,
                        input logic [1:0] oh, input logic [31:0] rd_exp, input int gap);
        xfer_t x;
        done_t d;
        x.addr = a; x.wr = wr; x.data = data; x.gnt = oh;
        d.done = oh; d.rd = !wr; d.rdata = rd_exp; d.gap = gap;
        xfer_q.push_back(x);
        done_q.push_back(d);
    endtask

    // Holds the given requests until n done pulses have been seen, then drops them.
    task automatic hold_until(input logic [1:0] mask, input int n);
        int seen = 0;
        int budget = 0;
        req = mask;
        while (seen < n && budget < 60) begin
            tick();
            budget++;
            if (done != '0) seen++;
        end
        if (seen < n) check("timeout_done", 64'(seen), 64'(n));
        req = '0;
        tick();
    endtask

    initial begin
        repeat (3) tick();
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_bus_addr", 64'(bus_addr), 64'(IDLE_ADDR));
        check("rst_wrtEn", 64'(bus_wrtEn), 64'd0);
        reset = 1'b0;
        mon_en = 1'b1;
        tick();

        // Write 0x2A to the LED from requester 0.
        we[0] = 1'b1; addr[31:0] = LED_ADDR; wdata[31:0] = 32'h2A;
        push(LED_ADDR, 1'b1, 32'h2A, 2'b01, 32'h0, 0);
        hold_until(2'b01, 1);
        check("led_after_write", 64'(led), 64'h02A);

        // Read it back from requester 1.
        we[1] = 1'b0; addr[63:32] = LED_ADDR;
        push(LED_ADDR, 1'b0, 32'h2A, 2'b10, 32'h2A, 0);
        hold_until(2'b10, 1);

        // Contention: both write, pointer now at 0 -> 0,1,0,1 each 3 cycles apart.
        we = 2'b11;
        addr = {32'h0000_0204, 32'h0000_0200};
        wdata = {32'h0000_1111, 32'h0000_2222};
        push(32'h200, 1'b1, 32'h2222, 2'b01, 32'h0, 0);
        push(32'h204, 1'b1, 32'h1111, 2'b10, 32'h0, 3);
        push(32'h200, 1'b1, 32'h2222, 2'b01, 32'h0, 3);
        push(32'h204, 1'b1, 32'h1111, 2'b10, 32'h0, 3);
        hold_until(2'b11, 4);

        // One-cycle req pulse: latched write of 0x15 still completes.
        we[0] = 1'b1; addr[31:0] = LED_ADDR; wdata[31:0] = 32'h15;
        push(LED_ADDR, 1'b1, 32'h15, 2'b01, 32'h0, 0);
        req = 2'b01;
        tick();
        req = '0;
        we[0] = 1'b0; wdata[31:0] = 32'h0;
        repeat (4) tick();
        check("led_after_pulse", 64'(led), 64'h015);

        // Reset during XFER of a write: bus idles next edge, no done pulse.
        we[1] = 1'b1; addr[63:32] = 32'h300; wdata[63:32] = 32'h77;
        begin
            xfer_t x;
            x.addr = 32'h300; x.wr = 1'b1; x.data = 32'h77; x.gnt = 2'b10;
            xfer_q.push_back(x);
        end
        req = 2'b10;
        tick();
        reset = 1'b1;
        req = '0;
        tick();
        check("rstx_bus_addr", 64'(bus_addr), 64'(IDLE_ADDR));
        check("rstx_wrtEn", 64'(bus_wrtEn), 64'd0);
        check("rstx_gnt", 64'(gnt), 64'd0);
        check("rstx_done", 64'(done), 64'd0);
        reset = 1'b0;
        tick();

        // Back-to-back reads from requester 0.
        we[0] = 1'b0; addr[31:0] = LED_ADDR;
        push(LED_ADDR, 1'b0, 32'h15, 2'b01, 32'h15, 0);
        push(LED_ADDR, 1'b0, 32'h15, 2'b01, 32'h15, RD_GAP);
        hold_until(2'b01, 2);

        repeat (6) tick();
        check("xfer_q_empty", 64'(xfer_q.size()), 64'd0);
        check("done_q_empty", 64'(done_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
